alu_exec_unit: RTL and testbench

Execute-stage arithmetic unit that consumes the 4-bit alu_ctrl code produced by the ALU control decoder, together with the two register operands. Single-cycle ops (add/sub/and/or/nor/slt, mfhi/mflo) return a registered result one edge after start. Multiply/divide run iteratively over 32 cycles with HI/LO result registers. A start/busy/done handshake lets the datapath stall while a multi-cycle op is in flight.

---
 rtl/alu_exec_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus iterative mult/div
// feeding HI/LO, with a start/busy/done handshake for datapath stalls.
//
// state  | meaning
// S_IDLE | ready; single-cycle ops complete here, mult/div are accepted here
// S_MUL  | shift-add multiply, one multiplier bit per edge
// S_DIV  | restoring divide, one quotient bit per edge
// S_FIX  | sign correction, HI/LO write, done
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             invalid,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               invalid_q, invalid_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        signed_op = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // Remainder shifted left with the next dividend bit; the extra top bit
        // doubles as the borrow of the trial subtraction.
        rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = rem_sh - {1'b0, opnd_q};

        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_res_q ? -prod : prod;
        quo_fix   = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        is_div_d   = is_div_q;
        b_zero_d   = b_zero_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        invalid_d  = invalid_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    invalid_d  = 1'b0;
                    div_zero_d = 1'b0;
                    done_d     = 1'b1;
                    case (alu_ctrl)
                        OP_AND:  result_d = a & b;
                        OP_OR:   result_d = a | b;
                        OP_ADD:  result_d = a + b;
                        OP_SUB:  result_d = a - b;
                        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                        OP_NOR:  result_d = ~(a | b);
                        OP_MFHI: result_d = hi_q;
                        OP_MFLO: result_d = lo_q;
                        OP_MULT, OP_MULTU: begin
                            done_d    = 1'b0;
                            busy_d    = 1'b1;
                            state_d   = S_MUL;
                            cnt_d     = '0;
                            acc_hi_d  = '0;
                            acc_lo_d  = b_mag;
                            opnd_d    = a_mag;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            b_zero_d  = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            done_d    = 1'b0;
                            busy_d    = 1'b1;
                            state_d   = S_DIV;
                            cnt_d     = '0;
                            acc_hi_d  = '0;
                            acc_lo_d  = a_mag;
                            opnd_d    = b_mag;
                            a_raw_d   = a;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            is_div_d  = 1'b1;
                            b_zero_d  = (b == '0);
                        end
                        default: begin
                            result_d  = '0;
                            invalid_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_hi_d = div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = rem_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                result_d   = lo_d;
                invalid_d  = 1'b0;
                div_zero_d = is_div_q & b_zero_q;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            invalid_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            is_div_q   <= is_div_d;
            b_zero_q   <= b_zero_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            invalid_q  <= invalid_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign invalid  = invalid_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, mult/div latency and
// results, start-while-busy, and reset abort.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done, invalid, div_zero;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.WIDTH(32), .ITER_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .busy     (busy),
        .done     (done),
        .invalid  (invalid),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic [3:0] c, input logic [31:0] va, input logic [31:0] vb);
        start    = 1'b1;
        alu_ctrl = c;
        a        = va;
        b        = vb;
        tick();
        start    = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
    endtask

    task automatic run_md(input string tag, input logic [3:0] c, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz);
        int lat;
        op1(c, va, vb);
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_done_e0"}, done, 0);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_result"}, result, el);
        chk({tag, "_divzero"}, div_zero, edz);
        chk({tag, "_busy_end"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; alu_ctrl = 4'd0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_invalid", invalid, 0);

        op1(4'd2, 32'd5, 32'd7);
        chk("add_done", done, 1);
        chk("add_result", result, 32'd12);
        chk("add_zero", zero, 0);
        chk("add_busy", busy, 0);
        tick();
        chk("add_done_pulse", done, 0);

        op1(4'd6, 32'h1234, 32'h1234);
        chk("sub_result", result, 0);
        chk("sub_zero", zero, 1);
        op1(4'd7, 32'hFFFF_FFFF, 32'd1);
        chk("slt_result", result, 1);
        op1(4'd7, 32'd1, 32'hFFFF_FFFF);
        chk("slt_false", result, 0);
        op1(4'd12, 32'd0, 32'd0);
        chk("nor_result", result, 32'hFFFF_FFFF);
        op1(4'd2, 32'hFFFF_FFFF, 32'd2);
        chk("add_wrap", result, 32'd1);

        // back-to-back single-cycle starts
        start = 1'b1; alu_ctrl = 4'd0; a = 32'hF0F0; b = 32'hFF00;
        tick();
        chk("b2b_and_done", done, 1);
        chk("b2b_and", result, 32'hF000);
        alu_ctrl = 4'd1;
        tick();
        start = 1'b0;
        chk("b2b_or_done", done, 1);
        chk("b2b_or", result, 32'hFFF0);

        run_md("mult", 4'd8, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_md("multu", 4'd9, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);
        run_md("mult_nn", 4'd8, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 1'b0);
        run_md("div", 4'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_md("divu_z", 4'd11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
        run_md("div_min", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // add requested mid-multiply must be ignored
        op1(4'd8, 32'hFFFF_0000, 32'h0003_0000);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 9) begin
                start = 1'b1; alu_ctrl = 4'd2; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (lat == 10) begin
                chk("ign_done", done, 0);
                chk("ign_busy", busy, 1);
            end
        end
        start = 1'b0;
        chk("ign_latency", lat, 33);
        chk("ign_hi", hi, 32'hFFFF_FFFD);
        chk("ign_lo", lo, 32'd0);
        tick();
        op1(4'd13, 32'd0, 32'd0);
        chk("mfhi_result", result, 32'hFFFF_FFFD);
        op1(4'd14, 32'd0, 32'd0);
        chk("mflo_result", result, 32'd0);
        chk("mflo_zero", zero, 1);
        chk("mflo_hi_kept", hi, 32'hFFFF_FFFD);

        // start held through the FIX edge is taken one edge later
        start = 1'b1; alu_ctrl = 4'd11; a = 32'd100; b = 32'd7;
        tick();
        alu_ctrl = 4'd2; a = 32'd3; b = 32'd4;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("hold_latency", lat, 33);
        chk("hold_quot", result, 32'd14);
        chk("hold_rem", hi, 32'd2);
        tick();
        start = 1'b0;
        chk("hold_next_done", done, 1);
        chk("hold_next_add", result, 32'd7);
        chk("hold_hi_kept", hi, 32'd2);
        tick();
        chk("hold_done_pulse", done, 0);

        // reset aborts a divide in flight
        op1(4'd10, 32'd1000, 32'd3);
        for (int i = 0; i < 14; i++) tick();
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        op1(4'd5, 32'd11, 32'd22);
        chk("inv_flag", invalid, 1);
        chk("inv_result", result, 0);
        chk("inv_zero", zero, 1);
        chk("inv_done", done, 1);
        chk("inv_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
